// File: rtl/i2c_target_rx.sv
// I2C target-side write receiver: synchronises SCL/SDA, detects START/STOP,
// matches a 7-bit address, shifts in write bytes, ACKs them and hands them
// to local logic over a valid/ready port, stretching SCL when that port is full.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   scl_in, sda_in    raw bus pin levels
//   scl_oe, sda_oe    1 = pull the line low (open-drain)
//   rx_data, rx_valid received byte and its valid flag
//   rx_ready          consumer accepts rx_data when rx_valid & rx_ready
//   busy              FSM is not idle
//   stretching        SCL is being held low (same as scl_oe)
//   timeout           one-cycle pulse when a stretch gives up
module i2c_target_rx #(
    parameter logic [6:0]  ADDR        = 7'h42,
    parameter logic [15:0] STRETCH_MAX = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       stretching,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_STRETCH,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t      state;
    logic        scl_q1, scl_q2, scl_h;
    logic        sda_q1, sda_q2, sda_h;
    logic [2:0]  cnt;
    logic        byte_done;
    logic [7:0]  shift;
    logic [15:0] scnt;

    logic scl_rise, scl_fall, start_c, stop_c;

    // Two-flop synchroniser plus one history flop per line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q1 <= 1'b1;
            scl_q2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_q1 <= 1'b1;
            sda_q2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_q1 <= scl_in;
            scl_q2 <= scl_q1;
            scl_h  <= scl_q2;
            sda_q1 <= sda_in;
            sda_q2 <= sda_q1;
            sda_h  <= sda_q2;
        end
    end

    assign scl_rise = scl_q2 & ~scl_h;
    assign scl_fall = ~scl_q2 & scl_h;
    // SCL must be high in both samples so an SDA move is a bus condition.
    assign start_c  = scl_q2 & scl_h & sda_h & ~sda_q2;
    assign stop_c   = scl_q2 & scl_h & ~sda_h & sda_q2;

    assign busy       = (state != S_IDLE);
    assign stretching = scl_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            byte_done <= 1'b0;
            shift     <= 8'h00;
            scnt      <= 16'd0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            // A load later in this block overrides the clear.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (stop_c && state != S_IDLE) begin
                state     <= S_IDLE;
                scl_oe    <= 1'b0;
                sda_oe    <= 1'b0;
                cnt       <= 3'd0;
                byte_done <= 1'b0;
            end else if (start_c) begin
                state     <= S_ADDR;
                scl_oe    <= 1'b0;
                sda_oe    <= 1'b0;
                cnt       <= 3'd0;
                byte_done <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_ADDR, S_DATA: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_q2};
                            cnt   <= cnt + 3'd1;
                            if (cnt == 3'd7)
                                byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (state == S_ADDR) begin
                                if (shift[7:1] == ADDR && !shift[0]) begin
                                    sda_oe <= 1'b1;
                                    state  <= S_ADDR_ACK;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end else if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                                sda_oe   <= 1'b1;
                                state    <= S_DATA_ACK;
                            end else begin
                                // Consumer still full: hold SCL low.
                                scl_oe <= 1'b1;
                                scnt   <= 16'd1;
                                state  <= S_STRETCH;
                            end
                        end
                    end
                    S_ADDR_ACK, S_DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= S_DATA;
                        end
                    end
                    S_STRETCH: begin
                        if (scnt != 16'hFFFF)
                            scnt <= scnt + 16'd1;
                        // Handshake beats a timeout in the same cycle.
                        if (rx_valid && rx_ready) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            scl_oe   <= 1'b0;
                            sda_oe   <= 1'b1;
                            state    <= S_DATA_ACK;
                        end else if (scnt == STRETCH_MAX) begin
                            timeout <= 1'b1;
                            scl_oe  <= 1'b0;
                            state   <= S_IGNORE;
                        end
                    end
                    S_IGNORE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: a bit-banged I2C controller drives
// two targets (long and short stretch limit) and a scoreboard checks bytes.
module tb_i2c_target_rx;

    localparam int H = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    logic sel = 1'b0;
    logic rx_ready = 1'b0;

    logic a_scl_in, a_sda_in, a_scl_oe, a_sda_oe, a_valid, a_ready;
    logic a_busy, a_str, a_to;
    logic [7:0] a_data;
    logic b_scl_in, b_sda_in, b_scl_oe, b_sda_oe, b_valid, b_ready;
    logic b_busy, b_str, b_to;
    logic [7:0] b_data;

    logic scl_bus, sda_bus;
    assign scl_bus = scl_drv & ~a_scl_oe & ~b_scl_oe;
    assign sda_bus = sda_drv & ~a_sda_oe & ~b_sda_oe;

    assign a_scl_in = sel ? 1'b1 : scl_bus;
    assign a_sda_in = sel ? 1'b1 : sda_bus;
    assign b_scl_in = sel ? scl_bus : 1'b1;
    assign b_sda_in = sel ? sda_bus : 1'b1;
    assign a_ready  = sel ? 1'b0 : rx_ready;
    assign b_ready  = sel ? rx_ready : 1'b0;

    logic m_valid, m_ready, m_scl_oe, m_sda_oe, m_busy, m_to, m_str;
    logic [7:0] m_data;
    assign m_valid  = sel ? b_valid  : a_valid;
    assign m_ready  = sel ? b_ready  : a_ready;
    assign m_scl_oe = sel ? b_scl_oe : a_scl_oe;
    assign m_sda_oe = sel ? b_sda_oe : a_sda_oe;
    assign m_busy   = sel ? b_busy   : a_busy;
    assign m_to     = sel ? b_to     : a_to;
    assign m_str    = sel ? b_str    : a_str;
    assign m_data   = sel ? b_data   : a_data;

    i2c_target_rx #(.ADDR(7'h42), .STRETCH_MAX(16'd50000)) u_dut (
        .clk(clk), .rst(rst), .scl_in(a_scl_in), .sda_in(a_sda_in),
        .scl_oe(a_scl_oe), .sda_oe(a_sda_oe), .rx_data(a_data),
        .rx_valid(a_valid), .rx_ready(a_ready), .busy(a_busy),
        .stretching(a_str), .timeout(a_to)
    );

    i2c_target_rx #(.ADDR(7'h42), .STRETCH_MAX(16'd64)) u_dut_to (
        .clk(clk), .rst(rst), .scl_in(b_scl_in), .sda_in(b_sda_in),
        .scl_oe(b_scl_oe), .sda_oe(b_sda_oe), .rx_data(b_data),
        .rx_valid(b_valid), .rx_ready(b_ready), .busy(b_busy),
        .stretching(b_str), .timeout(b_to)
    );

    int errs = 0;
    int checks = 0;
    logic [7:0] sb[$];
    int vcycles = 0;
    bit sda_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every transfer on the consumer port pops one byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) vcycles++;
            if (m_sda_oe) sda_seen = 1'b1;
            if (m_valid && m_ready) begin
                chk("sb_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0)
                    chk("sb_data", m_data, sb.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_high();
        int w;
        w = 0;
        scl_drv = 1'b1;
        while (scl_bus !== 1'b1 && w < 5000) begin
            tick();
            w++;
        end
        if (w == 5000) chk("scl_stuck", scl_bus, 1);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;
        tick(H);
        scl_high();
        tick(H);
        scl_drv = 1'b0;
        tick(H);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_drv = 1'b1;
        tick(H);
        scl_high();
        tick(H / 2);
        ack = sda_bus;
        tick(H / 2);
        scl_drv = 1'b0;
        tick(H);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        tick(H);
        scl_high();
        tick(H);
        sda_drv = 1'b0;
        tick(H);
        scl_drv = 1'b0;
        tick(H);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        tick(H);
        scl_high();
        tick(H);
        sda_drv = 1'b1;
        tick(H);
    endtask

    task automatic wait_stretch(output int w);
        w = 0;
        while (m_scl_oe !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ack;
        int w;
        int n;

        #1 rst = 1'b1;
        #2;
        chk("rst_scl_oe", a_scl_oe, 0);
        chk("rst_sda_oe", a_sda_oe, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 8'h00);
        chk("rst_busy", a_busy, 0);
        chk("rst_timeout", a_to, 0);
        chk("rst_stretching", a_str, 0);
        tick(3);
        rst = 1'b0;
        tick(5);

        // Plain write with the consumer always ready.
        rx_ready = 1'b1;
        vcycles = 0;
        i2c_start();
        send_byte(8'h84, ack);
        chk("t1_addr_ack", ack, 0);
        sb.push_back(8'hA5);
        send_byte(8'hA5, ack);
        chk("t1_data_ack", ack, 0);
        chk("t1_busy_mid", m_busy, 1);
        i2c_stop();
        tick(5);
        chk("t1_busy_end", m_busy, 0);
        chk("t1_valid_cycles", vcycles, 1);
        chk("t1_sb_empty", sb.size(), 0);

        // Foreign address is ignored until STOP.
        sda_seen = 1'b0;
        vcycles = 0;
        i2c_start();
        send_byte(8'h86, ack);
        chk("t2_addr_nack", ack, 1);
        send_byte(8'h55, ack);
        chk("t2_data_nack", ack, 1);
        chk("t2_busy_ignore", m_busy, 1);
        i2c_stop();
        tick(5);
        chk("t2_busy_end", m_busy, 0);
        chk("t2_no_sda", sda_seen, 0);
        chk("t2_no_valid", vcycles, 0);
        i2c_start();
        send_byte(8'h84, ack);
        chk("t2_reack", ack, 0);
        i2c_stop();

        // Own address with read bit set.
        vcycles = 0;
        i2c_start();
        send_byte(8'h85, ack);
        chk("t3_read_nack", ack, 1);
        send_byte(8'h33, ack);
        chk("t3_data_nack", ack, 1);
        i2c_stop();
        tick(5);
        chk("t3_no_valid", vcycles, 0);

        // Full buffer stretches SCL until the consumer takes the old byte.
        rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h84, ack);
        sb.push_back(8'h11);
        send_byte(8'h11, ack);
        chk("t4_ack11", ack, 0);
        chk("t4_hold_data", m_data, 8'h11);
        chk("t4_hold_valid", m_valid, 1);
        sb.push_back(8'h22);
        fork
            send_byte(8'h22, ack);
            begin
                wait_stretch(w);
                chk("t4_stretch", m_scl_oe, 1);
                chk("t4_stretching", m_str, 1);
                tick(100);
                chk("t4_still_stretch", m_scl_oe, 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                @(negedge clk);
                chk("t4_new_data", m_data, 8'h22);
                chk("t4_valid", m_valid, 1);
                chk("t4_release", m_scl_oe, 0);
                chk("t4_ack_drive", m_sda_oe, 1);
            end
        join
        chk("t4_ack22", ack, 0);
        i2c_stop();
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        tick(2);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_drained", m_valid, 0);

        // Stretch limit of 64 on the second target.
        sel = 1'b1;
        tick(5);
        i2c_start();
        send_byte(8'h84, ack);
        chk("t5_addr_ack", ack, 0);
        sb.push_back(8'h11);
        send_byte(8'h11, ack);
        fork
            send_byte(8'h22, ack);
            begin
                wait_stretch(w);
                n = 0;
                while (m_scl_oe === 1'b1 && n < 1000) begin
                    n++;
                    @(negedge clk);
                end
                chk("t5_stretch_len", n, 64);
                chk("t5_timeout", m_to, 1);
                @(negedge clk);
                chk("t5_timeout_pulse", m_to, 0);
            end
        join
        chk("t5_nack22", ack, 1);
        chk("t5_old_data", m_data, 8'h11);
        chk("t5_old_valid", m_valid, 1);
        i2c_stop();
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        tick(2);
        chk("t5_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of a stretch.
        sel = 1'b0;
        tick(5);
        i2c_start();
        send_byte(8'h84, ack);
        sb.push_back(8'h11);
        send_byte(8'h11, ack);
        fork
            send_byte(8'h22, ack);
            begin
                wait_stretch(w);
                chk("t6_stretch", m_scl_oe, 1);
                tick(20);
                #2 rst = 1'b1;
                #1;
                chk("t6_rst_scl", a_scl_oe, 0);
                chk("t6_rst_sda", a_sda_oe, 0);
                chk("t6_rst_valid", a_valid, 0);
                sb.delete();
                tick(3);
                rst = 1'b0;
            end
        join
        chk("t6_nack", ack, 1);
        i2c_stop();
        rx_ready = 1'b1;
        i2c_start();
        send_byte(8'h84, ack);
        chk("t6_reack", ack, 0);
        sb.push_back(8'h5A);
        send_byte(8'h5A, ack);
        chk("t6_data_ack", ack, 0);
        i2c_stop();
        tick(5);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_idle", m_busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
